// File: rtl/tt_scan_pkg.sv
// tt_scan_pkg: shared types and sizing for the truth-table scanner.
package tt_scan_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

   localparam int CNT_W = 8;

   function automatic int tbl_w(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: settle counter that raises expire on its SETTLE-th counted cycle.
module tt_settle_timer
   import tt_scan_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic expire
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = clr ? '0 : cnt_q + 1'b1;
      expire = cnt_q == CNT_W'(SETTLE - 1);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks x over 0..2^N-1, waits SETTLE cycles per vector and captures z into table_out.
// Defining TT_COMPARE_EN adds a check of every captured bit against expected_in.
module truth_table_scanner
   import tt_scan_pkg::*;
#(
   parameter  int N      = 4,
   parameter  int SETTLE = 1,
   localparam int TW     = tbl_w(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          z_in,
   output logic [N-1:0]  x_out,
   output logic          busy,
   output logic          done,
   output logic          valid,
   output logic [TW-1:0] table_out
`ifdef TT_COMPARE_EN
   ,
   input  logic [TW-1:0] expected_in,
   output logic [N:0]    mismatch_cnt,
   output logic [N-1:0]  first_mismatch,
   output logic          pass
`endif
);

   state_t          state_q, state_d;
   logic [N-1:0]    x_q, x_d;
   logic [TW-1:0]   table_q, table_d;
   logic            valid_q, valid_d;
   logic            expire, accept, sample;

   tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state_q != WAIT),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? WAIT : IDLE;
         WAIT:    state_d = expire ? SAMPLE : WAIT;
         SAMPLE:  state_d = &x_q ? DONE : WAIT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = state_q != IDLE;
      done = state_q == DONE;
   end

   always_comb begin
      accept  = state_q == IDLE && start;
      sample  = state_q == SAMPLE;
      x_d     = accept ? '0 : (sample && !(&x_q)) ? x_q + 1'b1 : x_q;
      valid_d = accept ? 1'b0 : done ? 1'b1 : valid_q;
      table_d = table_q;
      if (sample) table_d[x_q] = z_in;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         x_q     <= '0;
         table_q <= '0;
         valid_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         table_q <= table_d;
         valid_q <= valid_d;
      end

   assign x_out     = x_q;
   assign valid     = valid_q;
   assign table_out = table_q;

`ifdef TT_COMPARE_EN
   logic [TW-1:0] exp_q, exp_d;
   logic [N:0]    mcnt_q, mcnt_d;
   logic [N-1:0]  first_q, first_d;
   logic          pass_q, pass_d, miss;

   // first_mismatch only latches while the count is still zero
   always_comb begin
      miss    = sample && z_in != exp_q[x_q];
      exp_d   = accept ? expected_in : exp_q;
      mcnt_d  = accept ? '0 : miss ? mcnt_q + 1'b1 : mcnt_q;
      first_d = accept ? '0 : (miss && mcnt_q == '0) ? x_q : first_q;
      pass_d  = accept ? 1'b0 : done ? (mcnt_q == '0) : pass_q;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         exp_q   <= '0;
         mcnt_q  <= '0;
         first_q <= '0;
         pass_q  <= 1'b0;
      end else begin
         exp_q   <= exp_d;
         mcnt_q  <= mcnt_d;
         first_q <= first_d;
         pass_q  <= pass_d;
      end

   assign mismatch_cnt   = mcnt_q;
   assign first_mismatch = first_q;
   assign pass           = pass_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: directed checks of two scanners (SETTLE=1 on a minterm model, SETTLE=3 on constant 1).
module tb_truth_table_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic        z_a, z_b;
   logic        force9 = 1'b0;
   logic [3:0]  x_a, x_b;
   logic        busy_a, done_a, valid_a, busy_b, done_b, valid_b;
   logic [15:0] table_a, table_b;
   int          errors = 0, checks = 0;
`ifdef TT_COMPARE_EN
   logic [15:0] exp_a = 16'h0AC5;
   logic [4:0]  mcnt_a, mcnt_b;
   logic [3:0]  first_a, first_b;
   logic        pass_a, pass_b;
`endif

   always #5 clk = ~clk;

   // function under test: minterms {0,2,6,7,9,11}, bit 9 optionally forced low
   always_comb z_a = (x_a inside {4'd0, 4'd2, 4'd6, 4'd7, 4'd9, 4'd11}) && !(force9 && x_a == 4'd9);
   assign z_b = 1'b1;

   truth_table_scanner #(.N(4), .SETTLE(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .z_in(z_a), .x_out(x_a),
      .busy(busy_a), .done(done_a), .valid(valid_a), .table_out(table_a)
`ifdef TT_COMPARE_EN
      , .expected_in(exp_a), .mismatch_cnt(mcnt_a), .first_mismatch(first_a), .pass(pass_a)
`endif
   );

   truth_table_scanner #(.N(4), .SETTLE(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .z_in(z_b), .x_out(x_b),
      .busy(busy_b), .done(done_b), .valid(valid_b), .table_out(table_b)
`ifdef TT_COMPARE_EN
      , .expected_in(16'hFFFF), .mismatch_cnt(mcnt_b), .first_mismatch(first_b), .pass(pass_b)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // one pulsed-start scan on dut_a, done expected 32 edges after acceptance
   task automatic scan_a(input logic [15:0] exp_tbl);
      int k;
      @(negedge clk);
      start_a = 1'b1;
      cyc();
      start_a = 1'b0;
      chk("a_busy_run", busy_a, 1);
      chk("a_valid_run", valid_a, 0);
      k = 0;
      while (!done_a && k < 40) begin
         cyc();
         k++;
      end
      chk("a_done_edge", k, 32);
      chk("a_busy_done", busy_a, 1);
      cyc();
      chk("a_done_pulse", done_a, 0);
      chk("a_busy_after", busy_a, 0);
      chk("a_valid_after", valid_a, 1);
      chk("a_table", table_a, exp_tbl);
      chk("a_x_hold", x_a, 15);
   endtask

   initial begin
      int k;
      #12;
      chk("rst_x", x_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_valid", valid_a, 0);
      chk("rst_table", table_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk("idle_no_start", busy_a, 0);

      scan_a(16'h0AC5);

      // SETTLE=3, z tied high: x steps every 4 edges, done at edge 64
      start_b = 1'b1;
      cyc();
      start_b = 1'b0;
      chk("b_x_e0", x_b, 0);
      k = 0;
      while (!done_b && k < 80) begin
         cyc();
         k++;
         if (k == 3) chk("b_x_e3", x_b, 0);
         if (k == 4) chk("b_x_e4", x_b, 1);
         if (k == 8) chk("b_x_e8", x_b, 2);
         if (k == 63) chk("b_x_e63", x_b, 15);
      end
      chk("b_done_edge", k, 64);
      cyc();
      chk("b_table", table_b, 16'hFFFF);
      chk("b_valid", valid_b, 1);
      chk("b_busy", busy_b, 0);

      // start held high: one scan per acceptance, restart in first IDLE cycle
      start_a = 1'b1;
      cyc();
      for (int i = 0; i < 5; i++) cyc();
      chk("hold_x_e5", x_a, 2);
      k = 5;
      while (!done_a && k < 40) begin
         cyc();
         k++;
      end
      chk("hold_done_edge", k, 32);
      cyc();
      chk("hold_idle_busy", busy_a, 0);
      chk("hold_idle_valid", valid_a, 1);
      cyc();
      start_a = 1'b0;
      chk("hold_restart_busy", busy_a, 1);
      chk("hold_restart_valid", valid_a, 0);
      chk("hold_restart_x", x_a, 0);
      k = 0;
      while (!done_a && k < 40) begin
         cyc();
         k++;
      end
      chk("hold2_done_edge", k, 32);
      for (int i = 0; i < 3; i++) cyc();
      chk("hold2_no_third", busy_a, 0);
      chk("hold2_table", table_a, 16'h0AC5);

      // asynchronous reset mid-scan
      start_a = 1'b1;
      cyc();
      start_a = 1'b0;
      for (int i = 0; i < 9; i++) cyc();
      rst_n = 1'b0;
      #1;
      chk("arst_x", x_a, 0);
      chk("arst_busy", busy_a, 0);
      chk("arst_valid", valid_a, 0);
      chk("arst_table", table_a, 0);
      chk("arst_done", done_a, 0);
      #2;
      rst_n = 1'b1;
      scan_a(16'h0AC5);

`ifdef TT_COMPARE_EN
      force9 = 1'b1;
      scan_a(16'h08C5);
      chk("cmp_mcnt", mcnt_a, 1);
      chk("cmp_first", first_a, 9);
      chk("cmp_pass", pass_a, 0);
      force9 = 1'b0;
      scan_a(16'h0AC5);
      chk("cmp_mcnt_ok", mcnt_a, 0);
      chk("cmp_pass_ok", pass_a, 1);
      chk("cmp_b_pass", pass_b, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus-and-capture engine for combinational logic under test. On a start request it drives every input vector 0..2^N-1 onto a combinational block, waits a programmable settle time, and samples the block's single output. It assembles the complete truth table as a 2^N-bit vector. It sits on the driver/reader side of a gate-level function: the function maps x to z, and this block generates x and reads back z.

## Interface
Parameters:
- N, default 4: input width of the function under test; table width is 2^N.
- SETTLE, default 1: cycles each vector is held before sampling; legal range is 1..255.

Ports (name, direction, width, meaning):
- clk, input, 1: sole clock; all state is updated on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: scan request; sampled only in IDLE.
- z_in, input, 1: output of the function under test.
- x_out, output, N: vector currently applied.
- busy, output, 1: high from the start-acceptance edge until the cycle DONE exits.
- done, output, 1: one-cycle pulse when the scan completes.
- valid, output, 1: table_out holds a complete scan.
- table_out, output, 2^N: bit k holds the z captured for x = k.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE, start=1: x_out<=0, settle counter<=0, valid<=0, table_out unchanged, go to WAIT. start=0 keeps the block in IDLE.
- WAIT: the counter increments. When counter==SETTLE-1, go to SAMPLE.
- SAMPLE, which lasts one cycle: table_out[x_out]<=z_in.
  - If x_out==2^N-1, go to DONE.
  - Otherwise x_out<=x_out+1, counter<=0, go to WAIT.
- DONE, which lasts one cycle: done=1, busy=1. Next state is IDLE with valid<=1.
- x_out holds its last value (2^N-1) after a scan until the next start.
- start while not in IDLE is ignored, with no queuing.
- Arithmetic:
  - x_out increments in N bits, and the increment never wraps because DONE is taken first.
  - The settle counter is 8 bits wide.

## Timing
- Reset values: x_out=0, busy=0, done=0, valid=0, table_out=0, state=IDLE, counter=0.
- Each vector is held for exactly SETTLE+1 cycles: SETTLE in WAIT and 1 in SAMPLE. z_in is captured at the final edge of that window.
- With start accepted at edge E0, vector k is captured at edge E0+(k+1)(SETTLE+1).
  - done is high in the cycle after E0+2^N(SETTLE+1).
  - busy and valid change at edge E0+2^N(SETTLE+1)+1: busy falls and valid rises.
- N=4, SETTLE=1: 32 cycles to the last capture; done is asserted on cycle 33.
- Back-to-back scans: start is accepted in the first IDLE cycle after DONE.
- rst_n low mid-scan: all outputs and state return to reset values immediately (asynchronously). No partial table is retained.

## Configuration
- TT_COMPARE_EN defined adds the following:
  - input expected_in[2^N-1:0], latched at start acceptance;
  - outputs mismatch_cnt[N:0], first_mismatch[N-1:0] and pass.
  - At each SAMPLE, if z_in differs from the latched expected bit, mismatch_cnt increments. On the first mismatch only, first_mismatch<=x_out.
  - pass=1 from the exit of DONE when mismatch_cnt==0.
  - All three outputs reset to 0 and are cleared at start acceptance.
- TT_COMPARE_EN undefined: those ports and registers do not exist, and the rest of the behaviour is identical.

## Structure
- Package tt_scan_pkg holds:
  - the state enum (IDLE, WAIT, SAMPLE, DONE);
  - the settle-counter width constant (8);
  - a function returning table width 2^N.
- One sub-module, tt_settle_timer: an 8-bit counter with clear and an expire flag at SETTLE-1. Everything else lives in truth_table_scanner.

## Test plan
- N=4, SETTLE=1; z_in driven by a 4-input combinational model with minterms {0,2,6,7,9,11}; pulse start -> done on cycle 33, table_out=16'h0AC5, valid=1, busy=0 afterwards.
- SETTLE=3, z_in tied to 1 -> done on cycle 2^4*4+1=65, table_out=16'hFFFF; x_out steps once every 4 cycles.
- start held high through an entire scan -> exactly one scan per start acceptance; a second scan begins in the first IDLE cycle, and valid drops at that acceptance.
- rst_n pulsed low at cycle 10 of a scan -> all outputs are 0 in the same cycle; a restart gives the correct 16'h0AC5.
- TT_COMPARE_EN, expected_in=16'h0AC5 with the model's bit 9 forced to 0 -> mismatch_cnt=1, first_mismatch=9, pass=0.
- TT_COMPARE_EN with matching expected_in -> mismatch_cnt=0, pass=1 after done.
